// File: rtl/manchester_unescape.sv
// Byte-stream unescaper: strips ESCAPE_SYMBOL prefixes, converts raw ESCAPED_SYMBOL into a tuser frame-start flag.
// Optional saturating protocol-error counter enabled by defining MANCHESTER_UNESCAPE_ERRCNT_EN.
module manchester_unescape #(
  parameter int unsigned              DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]    ESCAPED_SYMBOL = 8'hD5,
  parameter logic [DATA_WIDTH-1:0]    ESCAPE_SYMBOL  = 8'hE5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  typedef enum logic {NORMAL, ESC} state_t;

  state_t                  state_q, state_d;
  logic                    sof_q, sof_d;
  logic                    emit_d;
  logic                    err_d;
  logic                    accept;
  logic                    is_esc, is_sof;
  logic                    m_tvalid_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;
  logic                    m_tlast_q;
  logic                    m_tuser_q;
  logic                    err_pulse_q;

  // Output slot is free when empty or being drained this cycle; held low in reset.
  assign s_axis_tready = aresetn && (!m_tvalid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign is_esc        = (s_axis_tdata == ESCAPE_SYMBOL);
  assign is_sof        = (s_axis_tdata == ESCAPED_SYMBOL);

  always_comb begin
    state_d = state_q;
    sof_d   = sof_q;
    emit_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        NORMAL: begin
          if (is_esc || is_sof) begin
            if (s_axis_tlast) begin
              // A control byte cannot close a frame: drop it and forget any frame start.
              err_d = 1'b1;
              sof_d = 1'b0;
            end else if (is_esc) begin
              state_d = ESC;
            end else begin
              sof_d = 1'b1;
            end
          end else begin
            emit_d = 1'b1;
            sof_d  = 1'b0;
          end
        end
        ESC: begin
          emit_d  = 1'b1;
          sof_d   = 1'b0;
          state_d = NORMAL;
          err_d   = !(is_esc || is_sof);
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= NORMAL;
      sof_q       <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sof_q       <= sof_d;
      err_pulse_q <= err_d;
      if (emit_d) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_tdata;
        m_tlast_q  <= s_axis_tlast;
        m_tuser_q  <= sof_q;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign err_pulse     = err_pulse_q;

`ifdef MANCHESTER_UNESCAPE_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_manchester_unescape.sv
// Self-checking bench for manchester_unescape: directed vector table, stall/reset sequences,
// and random streams checked against a lookahead reference model.
module tb_manchester_unescape;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        err_pulse;
  logic [15:0] err_count;

  manchester_unescape #(
    .DATA_WIDTH     (8),
    .ESCAPED_SYMBOL (8'hD5),
    .ESCAPE_SYMBOL  (8'hE5)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .err_pulse     (err_pulse),
    .err_count     (err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eu;
    logic       ee;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } out_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         tot_err  = 0;
  logic [7:0] sd[$];
  logic       sl[$];
  out_t       expq[$];
  vec_t       vt[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [7:0] d, logic l, logic ev, logic [7:0] ed,
                              logic el, logic eu, logic ee);
    vec_t v;
    v.d = d; v.l = l; v.ev = ev; v.ed = ed; v.el = el; v.eu = eu; v.ee = ee;
    return v;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef MANCHESTER_UNESCAPE_ERRCNT_EN
    return (tot_err > 65535) ? 16'hFFFF : tot_err[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Reference: an escape prefix (not closing a frame) swallows the following byte as its payload.
  task automatic model(output int errs);
    int   i   = 0;
    logic sof = 1'b0;
    out_t o;
    errs = 0;
    expq.delete();
    while (i < sd.size()) begin
      if (sd[i] == 8'hE5 && sl[i]) begin
        errs++; sof = 1'b0; i++;
      end else if (sd[i] == 8'hE5) begin
        if (i + 1 < sd.size()) begin
          o.d = sd[i+1]; o.l = sl[i+1]; o.u = sof;
          expq.push_back(o);
          if (sd[i+1] != 8'hE5 && sd[i+1] != 8'hD5) errs++;
          sof = 1'b0;
        end
        i += 2;
      end else if (sd[i] == 8'hD5) begin
        if (sl[i]) begin errs++; sof = 1'b0; end
        else sof = 1'b1;
        i++;
      end else begin
        o.d = sd[i]; o.l = sl[i]; o.u = sof;
        expq.push_back(o);
        sof = 1'b0; i++;
      end
    end
  endtask

  task automatic run_stream(input bit toggle, input string tag);
    int       n = sd.size();
    int       idx = 0, got = 0, cyc = 0, drain = 0, exp_err = 0, seen_err = 0, exp_total;
    bit       offering = 0, hold = 0;
    bit [3:0] tpat = 4'b1001;
    out_t     held, o, e;
    model(exp_err);
    exp_total = expq.size();
    while ((idx < n || expq.size() != 0 || drain < 4) && cyc < 40 * n + 100) begin
      @(negedge aclk);
      m_axis_tready = toggle ? tpat[cyc % 4] : ($urandom_range(0, 3) != 0);
      if (!offering && idx < n) offering = toggle || ($urandom_range(0, 4) != 0);
      s_axis_tvalid = offering;
      s_axis_tdata  = (idx < n) ? sd[idx] : 8'h00;
      s_axis_tlast  = (idx < n) ? sl[idx] : 1'b0;
      #1;
      if (err_pulse) seen_err++;
      o.d = m_axis_tdata; o.l = m_axis_tlast; o.u = m_axis_tuser;
      if (hold) begin
        chk({tag, " stall valid"}, {31'd0, m_axis_tvalid}, 32'd1);
        chk({tag, " stall data"}, {22'd0, o.d, o.l, o.u}, {22'd0, held.d, held.l, held.u});
      end
      hold = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          chk({tag, " unexpected output"}, {31'd0, m_axis_tvalid}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk({tag, " output"}, {22'd0, o.d, o.l, o.u}, {22'd0, e.d, e.l, e.u});
          got++;
        end
      end else if (m_axis_tvalid) begin
        hold = 1; held = o;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        idx++; offering = 0;
      end
      if (idx >= n && expq.size() == 0) drain++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    chk({tag, " inputs consumed"}, idx, n);
    chk({tag, " outputs delivered"}, got, exp_total);
    chk({tag, " err pulses"}, seen_err, exp_err);
    tot_err += exp_err;
    chk({tag, " err_count"}, {16'd0, err_count}, {16'd0, exp_cnt()});
  endtask

  initial begin
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;

    vt[0]  = mk(8'h11, 0, 1, 8'h11, 0, 0, 0);
    vt[1]  = mk(8'hE5, 0, 0, 8'h00, 0, 0, 0);
    vt[2]  = mk(8'hE5, 0, 1, 8'hE5, 0, 0, 0);
    vt[3]  = mk(8'hE5, 0, 0, 8'h00, 0, 0, 0);
    vt[4]  = mk(8'hD5, 0, 1, 8'hD5, 0, 0, 0);
    vt[5]  = mk(8'h22, 1, 1, 8'h22, 1, 0, 0);
    vt[6]  = mk(8'hD5, 0, 0, 8'h00, 0, 0, 0);
    vt[7]  = mk(8'hD5, 0, 0, 8'h00, 0, 0, 0);
    vt[8]  = mk(8'h33, 0, 1, 8'h33, 0, 1, 0);
    vt[9]  = mk(8'h44, 1, 1, 8'h44, 1, 0, 0);
    vt[10] = mk(8'hE5, 0, 0, 8'h00, 0, 0, 0);
    vt[11] = mk(8'h7A, 0, 1, 8'h7A, 0, 0, 1);
    vt[12] = mk(8'h01, 1, 1, 8'h01, 1, 0, 0);
    vt[13] = mk(8'h55, 0, 1, 8'h55, 0, 0, 0);
    vt[14] = mk(8'hE5, 1, 0, 8'h00, 0, 0, 1);
    vt[15] = mk(8'h66, 1, 1, 8'h66, 1, 0, 0);
    vt[16] = mk(8'hD5, 0, 0, 8'h00, 0, 0, 0);
    vt[17] = mk(8'hD5, 1, 0, 8'h00, 0, 0, 1);
    vt[18] = mk(8'h88, 1, 1, 8'h88, 1, 0, 0);
    vt[19] = mk(8'hD5, 0, 0, 8'h00, 0, 0, 0);
    vt[20] = mk(8'hE5, 0, 0, 8'h00, 0, 0, 0);
    vt[21] = mk(8'hD5, 1, 1, 8'hD5, 1, 1, 0);

    // Reset state
    #3;
    chk("reset tready", {31'd0, s_axis_tready}, 32'd0);
    chk("reset outputs", {19'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_pulse},
        32'd0);
    chk("reset err_count", {16'd0, err_count}, 32'd0);
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;

    // Directed table, one byte per cycle, sink always ready
    for (int k = 0; k < 22; k++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = vt[k].d; s_axis_tlast = vt[k].l;
      @(posedge aclk); #1;
      chk($sformatf("vec%0d valid", k), {31'd0, m_axis_tvalid}, {31'd0, vt[k].ev});
      if (vt[k].ev)
        chk($sformatf("vec%0d data", k), {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser},
            {22'd0, vt[k].ed, vt[k].el, vt[k].eu});
      chk($sformatf("vec%0d err_pulse", k), {31'd0, err_pulse}, {31'd0, vt[k].ee});
      if (vt[k].ee) tot_err++;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("table err_count", {16'd0, err_count}, {16'd0, exp_cnt()});

    // Stall pattern 1,0,0,1 over 10..1F
    sd.delete(); sl.delete();
    for (int b = 8'h10; b <= 8'h1F; b++) begin
      sd.push_back(8'(b)); sl.push_back(b == 8'h1F);
    end
    run_stream(1'b1, "stall");

    // Random streams weighted toward control bytes
    for (int r = 0; r < 3; r++) begin
      sd.delete(); sl.delete();
      for (int j = 0; j < 250; j++) begin
        int unsigned p = $urandom_range(0, 9);
        sd.push_back((p < 2) ? 8'hE5 : (p < 4) ? 8'hD5 : 8'($urandom_range(0, 255)));
        sl.push_back((j == 249) || ($urandom_range(0, 7) == 0));
      end
      run_stream(1'b0, $sformatf("rand%0d", r));
    end

    // Reset mid-escape with a stale data byte in the output register
    @(negedge aclk);
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    chk("pre-reset 77", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h77});
    @(negedge aclk);
    s_axis_tdata = 8'hE5;
    @(posedge aclk); #1;
    chk("pre-reset escape", {31'd0, m_axis_tvalid}, 32'd0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("async reset tready", {31'd0, s_axis_tready}, 32'd0);
    chk("async reset outputs",
        {19'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_pulse}, 32'd0);
    chk("async reset err_count", {16'd0, err_count}, 32'd0);
    tot_err = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hD5; s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    chk("post-reset D5 swallowed", {30'd0, m_axis_tvalid, err_pulse}, 32'd0);
    @(negedge aclk);
    s_axis_tdata = 8'h40; s_axis_tlast = 1'b1;
    @(posedge aclk); #1;
    chk("post-reset 40", {21'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_pulse},
        {21'd0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0});
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
